hilo_div_ctrl: RTL and testbench

- EX-stage controller for DIV/DIVU, and owner of the architectural HI/LO registers.
- Accepts a divide from EX and issues it to the iterative divider with a start/ready/annul handshake.
- Stalls the front of the pipeline while the divide runs, then commits {remainder, quotient} into HI/LO.
- Also takes MTHI/MTLO/MULT-style HI/LO writes from WB and drives hi_o/lo_o for MFHI/MFLO.

---
 rtl/hilo_div_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// rtl/hilo_div_ctrl.sv - EX-stage DIV/DIVU controller and HI/LO register owner (optional HILO_BYPASS_EN forwards WB writes to hi_o/lo_o)
module hilo_div_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_rs_i,
  input  logic [31:0] ex_rt_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  input  logic        wb_hi_we_i,
  input  logic        wb_lo_we_i,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              annul_q, annul_d;
  logic              timeout_q, timeout_d;
  logic              signed_q, signed_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              commit;

  // State and divider-interface registers; async reset drops start without an annul.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      annul_q   <= 1'b0;
      timeout_q <= 1'b0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      annul_q   <= annul_d;
      timeout_q <= timeout_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
    end
  end

  // Next-state, divider handshake and stall; flush beats ready beats timeout in WAIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = start_q;
    annul_d     = 1'b0;
    timeout_d   = 1'b0;
    signed_d    = signed_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    stall_req_o = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_div_i && !flush_i) begin
          stall_req_o = 1'b1;
          signed_d    = ex_signed_i;
          op1_d       = ex_rs_i;
          op2_d       = ex_rt_i;
          start_d     = 1'b1;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_req_o = !flush_i;
        cnt_d       = cnt_q + CNT_ONE;
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          state_d = ST_IDLE;
        end else if (div_ready_i) begin
          commit  = 1'b1;
          start_d = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          start_d   = 1'b0;
          annul_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        // One unstalled cycle lets EX advance and guarantees start is low between divides.
        state_d = ST_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // HI/LO update: WB writes are per-register, a divide commit overrides both.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_hi_we_i) hi_d = wb_hi_i;
    if (wb_lo_we_i) lo_d = wb_lo_i;
    if (commit) begin
      hi_d = div_result_i[63:32];
      lo_d = div_result_i[31:0];
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign div_start_o   = start_q;
  assign div_annul_o   = annul_q;
  assign div_timeout_o = timeout_q;
  assign div_signed_o  = signed_q;
  assign div_op1_o     = op1_q;
  assign div_op2_o     = op2_q;

`ifdef HILO_BYPASS_EN
  // Forward a WB write straight to the readers so MFHI/MFLO in EX sees it this cycle.
  assign hi_o = wb_hi_we_i ? wb_hi_i : hi_q;
  assign lo_o = wb_lo_we_i ? wb_lo_i : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb/tb_hilo_div_ctrl.sv - directed self-checking bench for hilo_div_ctrl
module tb_hilo_div_ctrl;
  logic        clk;
  logic        rst;
  logic        ex_div_i, ex_signed_i, flush_i;
  logic [31:0] ex_rs_i, ex_rt_i;
  logic        stall_req_o, div_start_o, div_annul_o, div_signed_o, div_timeout_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        wb_hi_we_i, wb_lo_we_i;
  logic [31:0] wb_hi_i, wb_lo_i;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;

  hilo_div_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .ex_div_i(ex_div_i), .ex_signed_i(ex_signed_i), .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i),
    .flush_i(flush_i), .stall_req_o(stall_req_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .wb_hi_we_i(wb_hi_we_i), .wb_lo_we_i(wb_lo_we_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .hi_o(hi_o), .lo_o(lo_o), .div_timeout_o(div_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ex_div_i = 0; ex_signed_i = 0; ex_rs_i = 0; ex_rt_i = 0; flush_i = 0;
    div_result_i = 0; div_ready_i = 0;
    wb_hi_we_i = 0; wb_lo_we_i = 0; wb_hi_i = 0; wb_lo_i = 0;
    step; step;
    checks++;
    if ({hi_o, lo_o, div_op1_o, div_op2_o} !== 128'h0) begin
      failures++; $display("FAIL reset_data: got hi=%h lo=%h op1=%h op2=%h, want all 0", hi_o, lo_o, div_op1_o, div_op2_o);
    end
    checks++;
    if ({div_start_o, div_annul_o, div_signed_o, div_timeout_o, stall_req_o} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b, want 00000", {div_start_o, div_annul_o, div_signed_o, div_timeout_o, stall_req_o});
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_signed_div;
    ex_signed_i = 1; ex_rs_i = 32'hFFFFFFF9; ex_rt_i = 32'h2; ex_div_i = 1;
    #1;
    checks++;
    if (stall_req_o !== 1'b1) begin failures++; $display("FAIL sdiv_accept_stall: got %b want 1", stall_req_o); end
    step;
    checks++;
    if ({div_start_o, div_signed_o, div_op1_o, div_op2_o} !== {2'b11, 32'hFFFFFFF9, 32'h2}) begin
      failures++; $display("FAIL sdiv_issue: got start=%b sgn=%b op1=%h op2=%h want 1 1 fffffff9 00000002", div_start_o, div_signed_o, div_op1_o, div_op2_o);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (stall_req_o !== 1'b1 || div_start_o !== 1'b1) begin
        failures++; $display("FAIL sdiv_wait_stall: cycle %0d stall=%b start=%b want 1 1", i, stall_req_o, div_start_o);
      end
      step;
    end
    div_ready_i = 1; div_result_i = {32'hFFFFFFFF, 32'hFFFFFFFD};
    #1;
    checks++;
    if (stall_req_o !== 1'b1) begin failures++; $display("FAIL sdiv_ready_stall: got %b want 1", stall_req_o); end
    step;
    div_ready_i = 0;
    #1;
    checks++;
    if ({stall_req_o, div_start_o, hi_o, lo_o} !== {2'b00, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      failures++; $display("FAIL sdiv_done: got stall=%b start=%b hi=%h lo=%h want 0 0 ffffffff fffffffd", stall_req_o, div_start_o, hi_o, lo_o);
    end
    step;
    ex_div_i = 0;
    #1;
    checks++;
    if (stall_req_o !== 1'b0 || div_start_o !== 1'b0) begin
      failures++; $display("FAIL sdiv_idle: got stall=%b start=%b want 0 0", stall_req_o, div_start_o);
    end
    step;
  endtask

  task automatic test_back_to_back;
    ex_signed_i = 0; ex_rs_i = 100; ex_rt_i = 7; ex_div_i = 1;
    step;
    step; step;
    div_ready_i = 1; div_result_i = {32'd2, 32'd14};
    step;
    div_ready_i = 0;
    #1;
    checks++;
    if ({hi_o, lo_o, div_signed_o} !== {32'd2, 32'd14, 1'b0}) begin
      failures++; $display("FAIL b2b_first: got hi=%h lo=%h sgn=%b want 00000002 0000000e 0", hi_o, lo_o, div_signed_o);
    end
    checks++;
    if (div_start_o !== 1'b0 || stall_req_o !== 1'b0) begin
      failures++; $display("FAIL b2b_gap_done: got start=%b stall=%b want 0 0", div_start_o, stall_req_o);
    end
    step;
    ex_rs_i = 32'hFFFFFFFF; ex_rt_i = 32'h10;
    #1;
    checks++;
    if (div_start_o !== 1'b0 || stall_req_o !== 1'b1) begin
      failures++; $display("FAIL b2b_gap_idle: got start=%b stall=%b want 0 1", div_start_o, stall_req_o);
    end
    step;
    checks++;
    if (div_start_o !== 1'b1 || div_op1_o !== 32'hFFFFFFFF || div_op2_o !== 32'h10) begin
      failures++; $display("FAIL b2b_second_issue: got start=%b op1=%h op2=%h want 1 ffffffff 00000010", div_start_o, div_op1_o, div_op2_o);
    end
    step;
    div_ready_i = 1; div_result_i = {32'hF, 32'h0FFFFFFF};
    step;
    div_ready_i = 0; ex_div_i = 0;
    checks++;
    if (hi_o !== 32'hF || lo_o !== 32'h0FFFFFFF) begin
      failures++; $display("FAIL b2b_second: got hi=%h lo=%h want 0000000f 0fffffff", hi_o, lo_o);
    end
    step;
  endtask

  task automatic test_div_zero;
    ex_signed_i = 1; ex_rs_i = 32'd5; ex_rt_i = 32'd0; ex_div_i = 1;
    step;
    checks++;
    if (div_start_o !== 1'b1 || div_op2_o !== 32'h0) begin
      failures++; $display("FAIL dz_issue: got start=%b op2=%h want 1 00000000", div_start_o, div_op2_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (div_timeout_o !== 1'b0) begin failures++; $display("FAIL dz_timeout: cycle %0d got %b want 0", i, div_timeout_o); end
      step;
    end
    div_ready_i = 1; div_result_i = 64'h0;
    step;
    div_ready_i = 0; ex_div_i = 0;
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || div_timeout_o !== 1'b0 || div_annul_o !== 1'b0) begin
      failures++; $display("FAIL dz_result: got hi=%h lo=%h to=%b an=%b want 0 0 0 0", hi_o, lo_o, div_timeout_o, div_annul_o);
    end
    step;
  endtask

  task automatic test_flush;
    wb_hi_we_i = 1; wb_lo_we_i = 1; wb_hi_i = 32'h1234; wb_lo_i = 32'h5678;
    #1;
`ifdef HILO_BYPASS_EN
    checks++;
    if (hi_o !== 32'h1234 || lo_o !== 32'h5678) begin
      failures++; $display("FAIL wb_bypass_both: got hi=%h lo=%h want 00001234 00005678", hi_o, lo_o);
    end
`else
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      failures++; $display("FAIL wb_no_bypass_both: got hi=%h lo=%h want 0 0", hi_o, lo_o);
    end
`endif
    step;
    wb_hi_we_i = 0; wb_lo_we_i = 0;
    checks++;
    if (hi_o !== 32'h1234 || lo_o !== 32'h5678) begin
      failures++; $display("FAIL wb_write: got hi=%h lo=%h want 00001234 00005678", hi_o, lo_o);
    end
    ex_signed_i = 0; ex_rs_i = 32'd50; ex_rt_i = 32'd3; ex_div_i = 1;
    step;
    for (int i = 0; i < 10; i++) step;
    flush_i = 1;
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b want 0", stall_req_o); end
    step;
    flush_i = 0; ex_div_i = 0;
    checks++;
    if (div_annul_o !== 1'b1 || div_start_o !== 1'b0 || div_timeout_o !== 1'b0) begin
      failures++; $display("FAIL flush_annul: got an=%b start=%b to=%b want 1 0 0", div_annul_o, div_start_o, div_timeout_o);
    end
    checks++;
    if (hi_o !== 32'h1234 || lo_o !== 32'h5678 || dut.state_q !== 2'd0) begin
      failures++; $display("FAIL flush_hold: got hi=%h lo=%h state=%0d want 00001234 00005678 0", hi_o, lo_o, dut.state_q);
    end
    step;
    checks++;
    if (div_annul_o !== 1'b0) begin failures++; $display("FAIL flush_annul_pulse: got %b want 0", div_annul_o); end
  endtask

  task automatic test_timeout;
    ex_signed_i = 0; ex_rs_i = 32'd9; ex_rt_i = 32'd1; ex_div_i = 1;
    step;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (stall_req_o !== 1'b1 || div_timeout_o !== 1'b0 || div_annul_o !== 1'b0) begin
        failures++; $display("FAIL to_wait: cycle %0d stall=%b to=%b an=%b want 1 0 0", i, stall_req_o, div_timeout_o, div_annul_o);
      end
      step;
    end
    checks++;
    if ({div_timeout_o, div_annul_o, div_start_o, stall_req_o} !== 4'b1100) begin
      failures++; $display("FAIL to_done: got to/an/start/stall=%b want 1100", {div_timeout_o, div_annul_o, div_start_o, stall_req_o});
    end
    checks++;
    if (hi_o !== 32'h1234 || lo_o !== 32'h5678) begin
      failures++; $display("FAIL to_hilo: got hi=%h lo=%h want 00001234 00005678", hi_o, lo_o);
    end
    ex_div_i = 0;
    step;
    checks++;
    if (div_timeout_o !== 1'b0 || div_annul_o !== 1'b0) begin
      failures++; $display("FAIL to_pulse: got to=%b an=%b want 0 0", div_timeout_o, div_annul_o);
    end
  endtask

  task automatic test_async_reset;
    ex_rs_i = 32'd77; ex_rt_i = 32'd7; ex_div_i = 1;
    step; step;
    checks++;
    if (div_start_o !== 1'b1) begin failures++; $display("FAIL ar_start: got %b want 1", div_start_o); end
    rst = 1; ex_div_i = 0;
    #1;
    checks++;
    if (div_start_o !== 1'b0 || stall_req_o !== 1'b0 || hi_o !== 32'h0 || dut.state_q !== 2'd0) begin
      failures++; $display("FAIL ar_immediate: got start=%b stall=%b hi=%h state=%0d want 0 0 0 0", div_start_o, stall_req_o, hi_o, dut.state_q);
    end
    step;
    rst = 0;
    step;
    checks++;
    if (div_annul_o !== 1'b0 || div_start_o !== 1'b0) begin
      failures++; $display("FAIL ar_no_annul: got an=%b start=%b want 0 0", div_annul_o, div_start_o);
    end
  endtask

  task automatic test_collision_bypass;
    ex_signed_i = 0; ex_rs_i = 32'd23; ex_rt_i = 32'd4; ex_div_i = 1;
    step; step;
    div_ready_i = 1; div_result_i = {32'h3, 32'h5};
    wb_hi_we_i = 1; wb_hi_i = 32'hAAAA0000; wb_lo_we_i = 1; wb_lo_i = 32'hBBBB0000;
    step;
    div_ready_i = 0; wb_hi_we_i = 0; wb_lo_we_i = 0; ex_div_i = 0;
    checks++;
    if (hi_o !== 32'h3 || lo_o !== 32'h5) begin
      failures++; $display("FAIL collide: got hi=%h lo=%h want 00000003 00000005", hi_o, lo_o);
    end
    step;
    wb_hi_we_i = 1; wb_hi_i = 32'h55AA55AA;
    #1;
`ifdef HILO_BYPASS_EN
    checks++;
    if (hi_o !== 32'h55AA55AA || lo_o !== 32'h5) begin
      failures++; $display("FAIL bypass_hi: got hi=%h lo=%h want 55aa55aa 00000005", hi_o, lo_o);
    end
`else
    checks++;
    if (hi_o !== 32'h3 || lo_o !== 32'h5) begin
      failures++; $display("FAIL nobypass_hi: got hi=%h lo=%h want 00000003 00000005", hi_o, lo_o);
    end
`endif
    step;
    wb_hi_we_i = 0;
    checks++;
    if (hi_o !== 32'h55AA55AA || lo_o !== 32'h5) begin
      failures++; $display("FAIL wb_hi_only: got hi=%h lo=%h want 55aa55aa 00000005", hi_o, lo_o);
    end
  endtask

  initial begin
    test_reset;
    test_signed_div;
    test_back_to_back;
    test_div_zero;
    test_flush;
    test_timeout;
    test_async_reset;
    test_collision_bypass;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
